regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file for the SLC-3 datapath, successor to the fixed 8×16 file. Adds:
- configurable width and depth;
- synchronous active-low reset of all state;
- same-cycle write-to-read bypass;
- a per-register busy scoreboard for in-flight loads;
- an NZP condition-code register updated from the written value.

It sits between the bus/MDR write-back path and the ALU operand muxes. The control FSM uses it to stall on pending destinations.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, register index width; DEPTH = 2**ADDR_W registers
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- wr_en  in  1  write strobe (equivalent of LD_REG)
- wr_addr  in  ADDR_W  destination register index
- wr_data  in  DATA_W  write-back data from bus
- ld_cc  in  1  update condition codes from wr_data
- rsv_en  in  1  mark rsv_addr busy (load issued)
- rsv_addr  in  ADDR_W  register to reserve
- rd_addr1, rd_addr2  in  ADDR_W  source register indices
- rd_data1, rd_data2  out  DATA_W  source operands
- busy1, busy2  out  1  source register has a pending write
- cc  out  3  {N,Z,P} condition codes
- any_busy  out  1  OR of all busy bits

## Operation
- Reset (reset=0 at a rising edge):
  - all registers load 0;
  - all busy bits load 0;
  - cc loads 3'b010;
  - wr_en, ld_cc and rsv_en are ignored that cycle.
- Write: when wr_en=1, mem[wr_addr] <= wr_data on the edge. wr_en=0 leaves all registers unchanged. No other register changes.
- Reads are combinational on rd_addr1/rd_addr2. Both ports are fully independent and may address the same register.
- Bypass: if wr_en=1, reset=1 and rd_addrN==wr_addr, then rd_dataN = wr_data. Otherwise rd_dataN = mem[rd_addrN].
- Condition codes: when ld_cc=1, cc <= {wr_data[DATA_W-1], wr_data==0, !wr_data[DATA_W-1] && wr_data!=0} on the edge.
  - Exactly one bit is set.
  - ld_cc is independent of wr_en and uses wr_data regardless.
- Scoreboard, per-register busy bit, next-state priority:
  - reset → 0;
  - else rsv_en && rsv_addr==i → 1;
  - else wr_en && wr_addr==i → 0;
  - else hold.
- Reserve and write to the same index in the same cycle: data is written and busy ends at 1. This is a new load issued behind the completing one.
- Reserve to an already-busy register: stays 1. No count is kept; there is one outstanding write per register.
- busyN bypass: busyN = busy[rd_addrN] & ~(wr_en && wr_addr==rd_addrN). Reserve does not bypass; it is visible from the next cycle.
- any_busy: registered OR of the busy vector, no bypass.
- Out-of-range indices cannot occur (DEPTH = 2**ADDR_W).

## Timing
- Write latency: 0 cycles to rd_data via bypass; 1 edge to storage.
- Read latency: combinational, 0 cycles.
- cc: valid the cycle after the ld_cc edge. cc holds otherwise.
- busy set: visible on busyN/any_busy 1 cycle after the rsv_en edge.
- busy clear: visible on busyN in the same cycle as wr_en (bypass); on any_busy after the edge.
- Reset mid-operation:
  - a write presented in the reset cycle is dropped;
  - bypass is suppressed while reset=0, so rd_data shows the stored contents;
  - outputs reach their reset values on the first edge with reset=0.
- Reset values of outputs after that edge:
  - rd_data1/2 = 0;
  - busy1/2 = 0;
  - any_busy = 0;
  - cc = 3'b010.

## Test plan
- Reset then sweep: after reset, rd_addr1 = 0..7 each reads 0x0000; cc = 010; any_busy = 0.
- Write/read all: write R_i = 0x1111*i, then read both ports. rd_data1(R5) = 0x5555; rd_data2(R7) = 0x7777 on the same cycle.
- Bypass: R3 holds 0x00AA. In one cycle wr_en=1, wr_addr=3, wr_data=0xBEEF, rd_addr1=3 → rd_data1 = 0xBEEF in that cycle. Next cycle, wr_en=0 → rd_data1 = 0xBEEF.
- Condition codes: ld_cc with wr_data = 0x8000 → cc = 100; then 0x0000 → 010; then 0x0001 → 001.
- Scoreboard with same-cycle reserve and write:
  - rsv_en on R2 → next cycle busy1 (rd_addr1=2) = 1 and any_busy = 1;
  - in the cycle wr_addr=2 is written → busy1 = 0 in that cycle;
  - simultaneous rsv R2 + wr R2 → busy stays 1 afterwards.
- Reset mid-operation: R4 = 0x1234 and busy[4] = 1. Assert reset with wr_en=1, wr_data=0xFFFF to R4 → after the edge, R4 = 0x0000, busy = 0, cc = 010.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass, per-register busy scoreboard
// for in-flight loads, and an NZP condition-code register.
module regfile_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ld_cc,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    output logic [2:0]        cc,
    output logic              any_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [2:0]        cc_q;
    logic              any_busy_q;
    logic              wr_hit1_s;
    logic              wr_hit2_s;

    function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] v);
        nzp_of = {v[DATA_W-1], (v == {DATA_W{1'b0}}), (~v[DATA_W-1]) & (v != {DATA_W{1'b0}})};
    endfunction

    // Busy next state: reset clears, a reserve outranks a completing write to the same index
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset) begin
                busy_d[i] = 1'b0;
            end else if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // Register storage
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Scoreboard, condition codes and summary busy flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q     <= {DEPTH{1'b0}};
            cc_q       <= 3'b010;
            any_busy_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            any_busy_q <= |busy_d;
            if (ld_cc) begin
                cc_q <= nzp_of(wr_data);
            end
        end
    end

    // Bypass the in-flight write to the read ports; suppressed while in reset
    always_comb begin
        wr_hit1_s = wr_en && (wr_addr == rd_addr1);
        wr_hit2_s = wr_en && (wr_addr == rd_addr2);
        if (wr_hit1_s && reset) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = mem_q[rd_addr1];
        end
        if (wr_hit2_s && reset) begin
            rd_data2 = wr_data;
        end else begin
            rd_data2 = mem_q[rd_addr2];
        end
        busy1 = busy_q[rd_addr1] & ~wr_hit1_s;
        busy2 = busy_q[rd_addr2] & ~wr_hit2_s;
    end

    assign cc       = cc_q;
    assign any_busy = any_busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios then random traffic, checked
// against an array-based reference model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset, wr_en, ld_cc, rsv_en;
    logic [2:0]  wr_addr, rsv_addr, rd_addr1, rd_addr2;
    logic [15:0] wr_data, rd_data1, rd_data2;
    logic        busy1, busy2, any_busy;
    logic [2:0]  cc;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_cc(ld_cc), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .busy1(busy1), .busy2(busy2), .cc(cc), .any_busy(any_busy)
    );

    typedef struct {
        logic [15:0] d1, d2;
        logic        b1, b2, ab;
        logic [2:0]  cc;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] m_mem[8];
    bit          m_busy[8];
    logic [2:0]  m_cc;
    int          total = 0;
    int          bad   = 0;
    int          ncyc  = 0;

    function automatic logic [2:0] cc_ref(input logic [15:0] v);
        if ($signed(v) < 0)  return 3'b100;
        else if (v == 16'd0) return 3'b010;
        else                 return 3'b001;
    endfunction

    function automatic void check(input string nm, input logic [15:0] got,
                                  input logic [15:0] exp, input int cyc);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endfunction

    task automatic model_reset();
        foreach (m_mem[i]) begin
            m_mem[i]  = 16'h0000;
            m_busy[i] = 1'b0;
        end
        m_cc = 3'b010;
    endtask

    task automatic step(input logic rst_v, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic lc, input logic re,
                        input logic [2:0] ra, input logic [2:0] a1, input logic [2:0] a2);
        exp_t e;
        bit   anyb;
        @(posedge clk); #1;
        reset = rst_v; wr_en = we; wr_addr = wa; wr_data = wd; ld_cc = lc;
        rsv_en = re; rsv_addr = ra; rd_addr1 = a1; rd_addr2 = a2;
        ncyc++;
        e.d1 = (rst_v && we && wa == a1) ? wd : m_mem[a1];
        e.d2 = (rst_v && we && wa == a2) ? wd : m_mem[a2];
        e.b1 = m_busy[a1] && !(we && wa == a1);
        e.b2 = m_busy[a2] && !(we && wa == a2);
        anyb = 1'b0;
        foreach (m_busy[i]) if (m_busy[i]) anyb = 1'b1;
        e.ab  = anyb;
        e.cc  = m_cc;
        e.cyc = ncyc;
        sbq.push_back(e);
        // state seen after the coming edge
        if (!rst_v) begin
            model_reset();
        end else begin
            if (we) m_mem[wa] = wd;
            if (lc) m_cc = cc_ref(wd);
            if (we) m_busy[wa] = 1'b0;
            if (re) m_busy[ra] = 1'b1;
        end
    endtask

    task automatic idle(input logic [2:0] a1, input logic [2:0] a2);
        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, a1, a2);
    endtask

    // Monitor: compare each presented cycle against the oldest expectation
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check("rd_data1", rd_data1, e.d1, e.cyc);
            check("rd_data2", rd_data2, e.d2, e.cyc);
            check("busy1", {15'd0, busy1}, {15'd0, e.b1}, e.cyc);
            check("busy2", {15'd0, busy2}, {15'd0, e.b2}, e.cyc);
            check("any_busy", {15'd0, any_busy}, {15'd0, e.ab}, e.cyc);
            check("cc", {13'd0, cc}, {13'd0, e.cc}, e.cyc);
        end
    end

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000; ld_cc = 1'b0;
        rsv_en = 1'b0; rsv_addr = 3'd0; rd_addr1 = 3'd0; rd_addr2 = 3'd0;
        repeat (2) @(posedge clk);
        model_reset();

        for (int i = 0; i < 8; i++) idle(3'(i), 3'(7 - i));
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 3'(i), 16'(16'h1111 * i), 1'b0, 1'b0, 3'd0, 3'(i), 3'd0);
        idle(3'd5, 3'd7);

        step(1'b1, 1'b1, 3'd3, 16'h00AA, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1);
        step(1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0, 3'd0, 3'd3, 3'd3);
        idle(3'd3, 3'd2);

        step(1'b1, 1'b0, 3'd0, 16'h8000, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
        step(1'b1, 1'b0, 3'd0, 16'h0001, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
        idle(3'd0, 3'd0);

        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd2, 3'd2, 3'd2);
        idle(3'd2, 3'd1);
        step(1'b1, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b0, 3'd0, 3'd2, 3'd2);
        step(1'b1, 1'b1, 3'd2, 16'h4242, 1'b0, 1'b1, 3'd2, 3'd2, 3'd0);
        idle(3'd2, 3'd2);

        step(1'b1, 1'b1, 3'd4, 16'h1234, 1'b0, 1'b1, 3'd4, 3'd0, 3'd0);
        idle(3'd4, 3'd4);
        step(1'b0, 1'b1, 3'd4, 16'hFFFF, 1'b1, 1'b1, 3'd4, 3'd4, 3'd4);
        idle(3'd4, 3'd2);

        repeat (400) begin
            step($urandom_range(0, 31) != 0, 1'($urandom), 3'($urandom), 16'($urandom),
                 1'($urandom), $urandom_range(0, 3) == 0, 3'($urandom),
                 3'($urandom), 3'($urandom));
        end

        repeat (3) @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
